// File: rtl/rsa_operand_sequencer.sv
// Operand sequencer for the RSA exponentiation core: fetches M, E, X, A, R2
// from memory one read at a time, launches the core, writes the result back.
module rsa_operand_sequencer #(
  parameter int READ_LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [16:0]    addr_m,
  input  logic [16:0]    addr_e,
  input  logic [16:0]    addr_x,
  input  logic [16:0]    addr_a,
  input  logic [16:0]    addr_r2,
  input  logic [16:0]    addr_res,
  input  logic [9:0]     exp_len_in,
  output logic [16:0]    mem_addr,
  input  logic [1023:0]  mem_rdata,
  output logic [1023:0]  mem_wdata,
  output logic [127:0]   mem_we,
  output logic [1023:0]  core_m,
  output logic [1023:0]  core_e,
  output logic [1023:0]  core_x,
  output logic [1023:0]  core_a,
  output logic [1023:0]  core_r2,
  output logic [9:0]     core_exp_len,
  output logic           core_start,
  input  logic           core_done,
  input  logic [1023:0]  core_result,
  output logic           busy,
  output logic           done
);

  localparam int NUM_OPS = 5;
  localparam int CW      = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_CORE, WRITEBACK, DONE} state_t;

  state_t                          state;
  logic [2:0]                      idx;
  logic [CW-1:0]                   cnt;
  logic [NUM_OPS-1:0][16:0]        lat_addr;
  logic [16:0]                     lat_res;
  logic [9:0]                      lat_len;
  logic [NUM_OPS-1:0][1023:0]      ops;

  assign core_m  = ops[0];
  assign core_e  = ops[1];
  assign core_x  = ops[2];
  assign core_a  = ops[3];
  assign core_r2 = ops[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_res      <= '0;
      lat_len      <= '0;
      ops          <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= '0;
      core_exp_len <= '0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      core_start <= 1'b0;
      mem_we     <= '0;
      case (state)
        IDLE: if (start) begin
          lat_addr <= {addr_r2, addr_a, addr_x, addr_e, addr_m};
          lat_res  <= addr_res;
          lat_len  <= exp_len_in;
          idx      <= '0;
          cnt      <= '0;
          mem_addr <= addr_m;
          busy     <= 1'b1;
          state    <= FETCH;
        end
        // Address held READ_LATENCY cycles, then one capture cycle per operand.
        FETCH: if (cnt == CW'(READ_LATENCY)) begin
          ops[idx] <= mem_rdata;
          cnt      <= '0;
          if (idx == 3'(NUM_OPS - 1)) begin
            core_exp_len <= lat_len;
            core_start   <= 1'b1;
            mem_addr     <= '0;
            state        <= WAIT_CORE;
          end else begin
            idx      <= idx + 3'd1;
            mem_addr <= lat_addr[idx + 3'd1];
          end
        end else begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(READ_LATENCY - 1)) mem_addr <= '0;
        end
        WAIT_CORE: if (core_done) begin
          mem_wdata <= core_result;
          mem_addr  <= lat_res;
          mem_we    <= '1;
          state     <= WRITEBACK;
        end
        WRITEBACK: begin
          mem_addr <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: if (!start) begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Randomized bench for rsa_operand_sequencer: two builds (READ_LATENCY 2 and 3)
// against a slot-addressed memory and a cycle-count reference of the fetch schedule.
module tb_rsa_operand_sequencer;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic                rst;
  logic [1:0]          start, core_done;
  logic [16:0]         addr_m, addr_e, addr_x, addr_a, addr_r2, addr_res;
  logic [9:0]          exp_len_in;
  logic [1023:0]       core_result;
  logic [1:0][16:0]    mem_addr;
  logic [1:0][1023:0]  mem_rdata, mem_wdata, core_m, core_e, core_x, core_a, core_r2;
  logic [1:0][127:0]   mem_we;
  logic [1:0][9:0]     core_exp_len;
  logic [1:0]          core_start, busy, done;

  rsa_operand_sequencer #(.READ_LATENCY(2)) u_rl2 (
    .clk(gclk), .rst(rst), .start(start[0]),
    .addr_m(addr_m), .addr_e(addr_e), .addr_x(addr_x), .addr_a(addr_a),
    .addr_r2(addr_r2), .addr_res(addr_res), .exp_len_in(exp_len_in),
    .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .core_m(core_m[0]), .core_e(core_e[0]), .core_x(core_x[0]),
    .core_a(core_a[0]), .core_r2(core_r2[0]), .core_exp_len(core_exp_len[0]),
    .core_start(core_start[0]), .core_done(core_done[0]), .core_result(core_result),
    .busy(busy[0]), .done(done[0]));

  rsa_operand_sequencer #(.READ_LATENCY(3)) u_rl3 (
    .clk(gclk), .rst(rst), .start(start[1]),
    .addr_m(addr_m), .addr_e(addr_e), .addr_x(addr_x), .addr_a(addr_a),
    .addr_r2(addr_r2), .addr_res(addr_res), .exp_len_in(exp_len_in),
    .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .core_m(core_m[1]), .core_e(core_e[1]), .core_x(core_x[1]),
    .core_a(core_a[1]), .core_r2(core_r2[1]), .core_exp_len(core_exp_len[1]),
    .core_start(core_start[1]), .core_done(core_done[1]), .core_result(core_result),
    .busy(busy[1]), .done(done[1]));

  // Memory: 8 slots at multiples of 128, read data READ_LATENCY cycles after the address.
  logic [1023:0] mem8 [8];
  logic [1023:0] wr_mem [8];
  int            wr_cnt [2] = '{0, 0};
  logic [16:0]   p2 [2];
  logic [16:0]   p3 [3];

  always @(posedge gclk) begin
    p2[0] <= mem_addr[0]; p2[1] <= p2[0];
    p3[0] <= mem_addr[1]; p3[1] <= p3[0]; p3[2] <= p3[1];
  end
  assign mem_rdata[0] = mem8[p2[1][9:7]];
  assign mem_rdata[1] = mem8[p3[2][9:7]];

  always @(posedge gclk)
    for (int d = 0; d < 2; d++)
      if (mem_we[d] != '0) begin
        wr_cnt[d] <= wr_cnt[d] + 1;
        wr_mem[mem_addr[d][9:7]] <= mem_wdata[d];
      end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (low 128b)", tag, got[127:0], exp[127:0]);
    end
  endtask

  task automatic tick;
    @(posedge gclk); #1;
  endtask

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [16:0] sa(input int s);
    return 17'(s * 128);
  endfunction

  function automatic int rs();
    return int'($urandom_range(0, 7));
  endfunction

  task automatic run(input int d, input int s_m, input int s_e, input int s_x,
                     input int s_a, input int s_r2, input int s_res,
                     input logic [9:0] el, input int lat, input bit spur,
                     input bit drop, input bit keep, input logic [1023:0] res);
    int rl, f, w0, op, ph;
    logic [16:0] a [5];
    rl = d ? 3 : 2;
    f  = 5 * (rl + 1);
    w0 = wr_cnt[d];
    a[0] = sa(s_m); a[1] = sa(s_e); a[2] = sa(s_x); a[3] = sa(s_a); a[4] = sa(s_r2);
    addr_m = a[0]; addr_e = a[1]; addr_x = a[2]; addr_a = a[3]; addr_r2 = a[4];
    addr_res = sa(s_res); exp_len_in = el; start[d] = 1'b1;
    tick;
    // Inputs after launch must not matter until the next start.
    addr_m = 17'($urandom); addr_e = 17'($urandom); addr_x = 17'($urandom);
    addr_a = 17'($urandom); addr_r2 = 17'($urandom); addr_res = 17'($urandom);
    exp_len_in = 10'($urandom);
    if (drop) start[d] = 1'b0;
    for (int k = 1; k <= f; k++) begin
      op = (k - 1) / (rl + 1);
      ph = (k - 1) % (rl + 1);
      chk("fetch_addr", 1024'(mem_addr[d]), 1024'(ph < rl ? a[op] : 17'd0));
      chk("fetch_busy", 1024'(busy[d]), 1024'(1));
      chk("fetch_no_core_start", 1024'(core_start[d]), 1024'(0));
      core_done[d] = spur && (k == 2 * (rl + 1) + 1);
      tick;
    end
    core_done[d] = 1'b0;
    chk("core_start", 1024'(core_start[d]), 1024'(1));
    chk("core_m", core_m[d], mem8[s_m]);
    chk("core_e", core_e[d], mem8[s_e]);
    chk("core_x", core_x[d], mem8[s_x]);
    chk("core_a", core_a[d], mem8[s_a]);
    chk("core_r2", core_r2[d], mem8[s_r2]);
    chk("core_exp_len", 1024'(core_exp_len[d]), 1024'(el));
    tick;
    chk("core_start_pulse", 1024'(core_start[d]), 1024'(0));
    for (int i = 0; i < lat; i++) begin
      chk("wait_no_we", 1024'(mem_we[d]), 1024'(0));
      tick;
    end
    core_result = res; core_done[d] = 1'b1; start[d] = keep;
    tick;
    core_done[d] = 1'b0; core_result = rand1024();
    chk("wb_we", 1024'(mem_we[d]), 1024'({128{1'b1}}));
    chk("wb_addr", 1024'(mem_addr[d]), 1024'(sa(s_res)));
    chk("wb_data", mem_wdata[d], res);
    chk("wb_busy", 1024'(busy[d]), 1024'(1));
    tick;
    chk("done", 1024'(done[d]), 1024'(1));
    chk("done_busy", 1024'(busy[d]), 1024'(0));
    chk("done_we", 1024'(mem_we[d]), 1024'(0));
    chk("done_addr", 1024'(mem_addr[d]), 1024'(0));
    chk("write_count", 1024'(wr_cnt[d] - w0), 1024'(1));
    chk("write_mem", wr_mem[s_res], res);
  endtask

  task automatic chk_zero(input int d);
    chk("rst_done", 1024'(done[d]), 1024'(0));
    chk("rst_busy", 1024'(busy[d]), 1024'(0));
    chk("rst_addr", 1024'(mem_addr[d]), 1024'(0));
    chk("rst_we", 1024'(mem_we[d]), 1024'(0));
    chk("rst_core_start", 1024'(core_start[d]), 1024'(0));
    chk("rst_core_m", core_m[d], '0);
    chk("rst_core_r2", core_r2[d], '0);
    chk("rst_wdata", mem_wdata[d], '0);
    chk("rst_exp_len", 1024'(core_exp_len[d]), 1024'(0));
  endtask

  logic [1023:0] r1, r2;
  int w;

  initial begin
    rst = 1'b1; start = '0; core_done = '0; core_result = '0; exp_len_in = '0;
    addr_m = '0; addr_e = '0; addr_x = '0; addr_a = '0; addr_r2 = '0; addr_res = '0;
    for (int i = 0; i < 8; i++) mem8[i] = rand1024();
    tick; tick;
    chk_zero(0); chk_zero(1);
    rst = 1'b0;
    tick;
    chk("idle_busy", 1024'(busy[0]), 1024'(0));

    // Nominal run with held start, then done handshake
    run(0, 0, 1, 2, 3, 4, 5, 10'd16, 50, 1'b0, 1'b0, 1'b1, 1024'hABCD);
    for (int i = 0; i < 100; i++) begin
      chk("hold_done", 1024'(done[0]), 1024'(1));
      tick;
    end
    start[0] = 1'b0;
    tick;
    chk("release_done", 1024'(done[0]), 1024'(0));
    tick; tick;
    chk("no_retrigger", 1024'(busy[0]), 1024'(0));
    chk("idle_addr", 1024'(mem_addr[0]), 1024'(0));

    // Back-to-back runs with one idle cycle between them
    r1 = rand1024(); r2 = rand1024();
    run(0, 0, 1, 2, 3, 4, 5, 10'd16, 10, 1'b0, 1'b0, 1'b1, r1);
    start[0] = 1'b0;
    tick;
    chk("b2b_gap_done", 1024'(done[0]), 1024'(0));
    run(0, 4, 3, 2, 1, 0, 6, 10'd1023, 10, 1'b0, 1'b0, 1'b0, r2);
    tick;
    chk("done_one_cycle", 1024'(done[0]), 1024'(0));
    chk("b2b_res1", wr_mem[5], r1);
    chk("b2b_res2", wr_mem[6], r2);

    // Spurious core_done during fetch of operand 2, start dropped mid-op
    run(0, rs(), rs(), rs(), rs(), rs(), rs(), 10'($urandom), 5, 1'b1, 1'b1, 1'b0, rand1024());
    tick;

    // Longer read latency build
    run(1, 0, 1, 2, 3, 4, 7, 10'd16, 3, 1'b0, 1'b0, 1'b0, rand1024());
    tick;

    for (int n = 0; n < 8; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) mem8[i] = rand1024();
      run(d, rs(), rs(), rs(), rs(), rs(), rs(), 10'($urandom),
          int'($urandom_range(1, 20)), 1'($urandom), 1'($urandom), 1'b0, rand1024());
      tick;
      chk("rand_done_drop", 1024'(done[d]), 1024'(0));
    end

    // Reset during WAIT_CORE, then a late core_done
    w = wr_cnt[0];
    addr_m = sa(1); addr_e = sa(2); addr_x = sa(3); addr_a = sa(4); addr_r2 = sa(5);
    addr_res = sa(6); exp_len_in = 10'd16; start[0] = 1'b1;
    tick;
    for (int i = 0; i < 17; i++) tick;
    start[0] = 1'b0; rst = 1'b1;
    #1;
    chk_zero(0);
    tick;
    rst = 1'b0; core_done[0] = 1'b1; core_result = rand1024();
    tick;
    core_done[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_we", 1024'(mem_we[0]), 1024'(0));
      chk("post_rst_done", 1024'(done[0]), 1024'(0));
      chk("post_rst_busy", 1024'(busy[0]), 1024'(0));
      tick;
    end
    chk("post_rst_writes", 1024'(wr_cnt[0] - w), 1024'(0));

    // Reset mid-fetch with start held; restarts on the first edge after release
    addr_m = sa(3);
    start[0] = 1'b1;
    tick; tick; tick;
    rst = 1'b1;
    #1;
    chk("rst_fetch_busy", 1024'(busy[0]), 1024'(0));
    chk("rst_fetch_addr", 1024'(mem_addr[0]), 1024'(0));
    tick;
    rst = 1'b0;
    tick;
    chk("restart_busy", 1024'(busy[0]), 1024'(1));
    chk("restart_addr", 1024'(mem_addr[0]), 1024'(sa(3)));
    rst = 1'b1; start[0] = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("restart_no_write", 1024'(wr_cnt[0] - w), 1024'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
